half_adder_checker: RTL and testbench
=====================================

// Module: half_adder_checker
//
// PURPOSE
//   Response-side companion to the registered half adder. Samples the same
//   a/b stimulus the adder receives and computes expected sum/carry.
//   Delays the expected values through a LATENCY-deep valid/data pipeline and
//   compares them against the adder's registered outputs.
//   Keeps check/error counters, a sticky fail flag and the index of the first
//   failing sample. Sits beside the adder in simulation and FPV harnesses.
//
// PARAMETERS
//   LATENCY       1   cycles from a/b/valid sampled to dut_sum/dut_carry valid (1..8)
//   CNT_W         16  width of chk_count, err_count, first_err_idx
//   STOP_ON_FAIL  0   1: enter HALT on first mismatch; 0: keep checking
//
// PORTS
//   clk            in   1      rising-edge clock
//   rst            in   1      asynchronous, active-high reset
//   en             in   1      checker enable; rising edge while IDLE starts a run
//   valid          in   1      a/b carry a stimulus sample this cycle
//   a              in   1      adder operand A (same net as DUT input)
//   b              in   1      adder operand B (same net as DUT input)
//   dut_sum        in   1      adder sum output
//   dut_carry      in   1      adder carry output
//   busy           out  1      1 while state == RUN
//   fail           out  1      sticky: at least one mismatch in current run
//   chk_count      out  CNT_W  comparisons performed in current run (saturating)
//   err_count      out  CNT_W  mismatches in current run (saturating)
//   first_err_idx  out  CNT_W  chk_count value at first mismatch (0-based)
//
// BEHAVIOUR
//   - Reset (async assert, sync release): state = IDLE; pipe valid bits = 0;
//     busy = 0; fail = 0; chk_count = 0; err_count = 0; first_err_idx = 0.
//   - Expected values: exp_sum = a ^ b, exp_carry = a & b.
//   - Pipeline: {valid, exp_sum, exp_carry} shift 1 stage/cycle, LATENCY stages.
//     Input is loaded only in RUN; in other states a 0 valid is shifted in.
//   - Compare: when the last stage is valid, (dut_sum, dut_carry) is compared
//     with the stage contents in that same cycle.
//   - FSM (states IDLE, RUN, HALT):
//     - IDLE: leaves for RUN when en = 1.
//       - On that edge: clear counters, fail and first_err_idx; clear pipe valid bits.
//     - RUN: every valid compare increments chk_count.
//       - Mismatch increments err_count.
//       - If fail was 0: set fail and latch first_err_idx = pre-increment chk_count.
//       - Mismatch with STOP_ON_FAIL = 1: go to HALT on the same edge.
//       - en = 0: go to IDLE; pipe valid bits are cleared, so in-flight samples are
//         dropped and not counted.
//     - HALT: no compares, counters frozen; en = 0 -> IDLE.
//   - Output timing: counters, fail and first_err_idx are registered and update on
//     the edge after the compare cycle; busy follows state.
//   - Saturation: counters hold at 2^CNT_W-1. A mismatch at chk_count
//     saturation still sets fail if it is clear.
//   - Simultaneous events:
//     - en falling in the same cycle as a valid compare: that compare IS counted,
//       then the FSM goes to IDLE.
//     - rst wins over everything.
//   - Reset mid-run: all state is discarded immediately; no partial counts survive.
//   - Outputs hold their values in IDLE until the next run starts.
//
// CONFIGURATION
//   HA_CHK_ASSERT_EN defined:
//     - Adds a clocked assertion: (state == RUN && compare valid) -> match.
//     - In simulation the assertion reports $error with chk_count, expected and
//       actual values; in the formal flow it is a checked assert property.
//   HA_CHK_ASSERT_EN undefined:
//     - No assertion logic. Mismatches are reported only via fail/err_count.
//     - Port list and counter behaviour are identical.
//
// TESTING
//   1. rst=1 for 2 cycles, en=0 -> all outputs 0, busy=0.
//   2. LATENCY=1, correct adder model, en=1, valid on ab=00,01,10,11
//      -> chk_count=4, err_count=0, fail=0.
//   3. As test 2 but invert dut_sum on the 3rd sample (ab=10)
//      -> err_count=1, fail=1, first_err_idx=2, chk_count=4.
//   4. STOP_ON_FAIL=1, carry forced 0 on ab=11 as the 2nd sample
//      -> state HALT, busy=0, chk_count=2, no further counting; en=0 -> IDLE.
//   5. CNT_W=2, 6 correct samples -> chk_count saturates at 3;
//      a mismatch on the 7th sample -> fail=1, err_count=1.
//   6. LATENCY=3; after 2 samples, assert rst while 2 samples are in flight
//      -> all outputs 0 immediately. Repeat with en=0 instead of rst
//      -> chk_count unchanged (in-flight samples dropped).

Source files
------------

// File: rtl/half_adder_checker.sv
// Purpose : response-side checker for a registered half adder; predicts sum/carry
//           from the shared a/b stimulus, delays the prediction LATENCY cycles and
//           compares it with the adder outputs, keeping counts and a sticky fail.
// Latency : a compare happens LATENCY cycles after a sample; counters update on the next edge.
// Backpressure : none; the checker observes only and never stalls the stimulus.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   en                  run enable (IDLE -> RUN while high, RUN/HALT -> IDLE when low)
//   valid, a, b         stimulus sample presented to the adder this cycle
//   dut_sum, dut_carry  registered adder outputs under test
//   busy                high while a run is active (not halted)
//   fail                sticky mismatch flag for the current run
//   chk_count           saturating number of compares in the current run
//   err_count           saturating number of mismatches in the current run
//   first_err_idx       chk_count value at the first mismatch of the run
//
// Build option: define HA_CHK_ASSERT_EN to add a clocked match assertion.

module half_adder_checker #(
  parameter int LATENCY      = 1,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid,
  input  logic             a,
  input  logic             b,
  input  logic             dut_sum,
  input  logic             dut_carry,
  output logic             busy,
  output logic             fail,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;

  logic [LATENCY-1:0] pipe_vld;
  logic [LATENCY-1:0] pipe_sum;
  logic [LATENCY-1:0] pipe_carry;

  logic cmp_vld;
  logic cmp_ok;
  logic mismatch;
  logic start_run;
  logic drop_run;

  // Compares only count while running; HALT freezes everything.
  assign cmp_vld   = (state == RUN) && pipe_vld[LATENCY-1];
  assign cmp_ok    = (dut_sum == pipe_sum[LATENCY-1]) && (dut_carry == pipe_carry[LATENCY-1]);
  assign mismatch  = cmp_vld && !cmp_ok;
  assign start_run = (state == IDLE) && en;
  assign drop_run  = (state == RUN) && !en;
  assign busy      = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN: begin
        // Dropping en wins over halting: the run ends either way.
        if (!en)                              state_nxt = IDLE;
        else if (STOP_ON_FAIL && mismatch)    state_nxt = HALT;
      end
      HALT: if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Expected-value pipeline. Valid bits are flushed at run start and when en drops,
  // so samples in flight across a run boundary are never compared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld   <= '0;
      pipe_sum   <= '0;
      pipe_carry <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        pipe_vld[i]   <= pipe_vld[i-1];
        pipe_sum[i]   <= pipe_sum[i-1];
        pipe_carry[i] <= pipe_carry[i-1];
      end
      pipe_vld[0]   <= (state == RUN) && valid;
      pipe_sum[0]   <= a ^ b;
      pipe_carry[0] <= a & b;
      if (start_run || drop_run) pipe_vld <= '0;
    end
  end

  // Counters. A compare in the same cycle en drops is still counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_count     <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      fail          <= 1'b0;
    end else if (start_run) begin
      chk_count     <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      fail          <= 1'b0;
    end else if (cmp_vld) begin
      if (chk_count != CNT_MAX) chk_count <= chk_count + 1'b1;
      if (!cmp_ok) begin
        if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
        // First failure records the pre-increment index, even at saturation.
        if (!fail) begin
          fail          <= 1'b1;
          first_err_idx <= chk_count;
        end
      end
    end
  end

`ifdef HA_CHK_ASSERT_EN
  ha_chk_match: assert property (@(posedge clk) disable iff (rst) cmp_vld |-> cmp_ok)
    else $error("half_adder_checker: mismatch at check %0d: expected sum=%0b carry=%0b, got sum=%0b carry=%0b",
                chk_count, pipe_sum[LATENCY-1], pipe_carry[LATENCY-1], dut_sum, dut_carry);
`endif

endmodule

// File: tb/tb_half_adder_checker.sv
// Bench for half_adder_checker: four instances share one stimulus stream
//   u0: LATENCY=1 CNT_W=16   u1: STOP_ON_FAIL=1   u2: CNT_W=2   u3: LATENCY=3
// A behavioural adder (with per-instance fault injection) drives each instance;
// a reference model of the run rules predicts every output after every edge.

module tb_half_adder_checker;

  localparam int MAXC = 4096;
  localparam int LAT[4] = '{1, 1, 1, 3};
  localparam int CW[4]  = '{16, 16, 2, 16};
  localparam int STP[4] = '{0, 1, 0, 0};

  logic clk, rst, en, valid, a, b;
  logic [3:0] dsum, dcar, busy_o, fail_o;
  logic [3:0] fs, fc;
  logic [15:0] chk0, err0, fe0, chk1, err1, fe1, chk3, err3, fe3;
  logic [1:0]  chk2, err2, fe2;
  int chk_a[4], err_a[4], fe_a[4];

  int checks, errors, cyc;

  logic       ha[MAXC];
  logic       hb[MAXC];
  logic [3:0] hfs[MAXC];
  logic [3:0] hfc[MAXC];
  logic [3:0] hld[MAXC];

  int m_state[4], m_chk[4], m_err[4], m_fe[4], m_flush[4];
  bit m_fail[4];

  half_adder_checker #(.LATENCY(1), .CNT_W(16), .STOP_ON_FAIL(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .valid(valid), .a(a), .b(b),
    .dut_sum(dsum[0]), .dut_carry(dcar[0]), .busy(busy_o[0]), .fail(fail_o[0]),
    .chk_count(chk0), .err_count(err0), .first_err_idx(fe0));
  half_adder_checker #(.LATENCY(1), .CNT_W(16), .STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .valid(valid), .a(a), .b(b),
    .dut_sum(dsum[1]), .dut_carry(dcar[1]), .busy(busy_o[1]), .fail(fail_o[1]),
    .chk_count(chk1), .err_count(err1), .first_err_idx(fe1));
  half_adder_checker #(.LATENCY(1), .CNT_W(2), .STOP_ON_FAIL(1'b0)) u2 (
    .clk(clk), .rst(rst), .en(en), .valid(valid), .a(a), .b(b),
    .dut_sum(dsum[2]), .dut_carry(dcar[2]), .busy(busy_o[2]), .fail(fail_o[2]),
    .chk_count(chk2), .err_count(err2), .first_err_idx(fe2));
  half_adder_checker #(.LATENCY(3), .CNT_W(16), .STOP_ON_FAIL(1'b0)) u3 (
    .clk(clk), .rst(rst), .en(en), .valid(valid), .a(a), .b(b),
    .dut_sum(dsum[3]), .dut_carry(dcar[3]), .busy(busy_o[3]), .fail(fail_o[3]),
    .chk_count(chk3), .err_count(err3), .first_err_idx(fe3));

  always_comb begin
    chk_a[0] = int'(chk0); err_a[0] = int'(err0); fe_a[0] = int'(fe0);
    chk_a[1] = int'(chk1); err_a[1] = int'(err1); fe_a[1] = int'(fe1);
    chk_a[2] = int'(chk2); err_a[2] = int'(err2); fe_a[2] = int'(fe2);
    chk_a[3] = int'(chk3); err_a[3] = int'(err3); fe_a[3] = int'(fe3);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_zero();
    for (int i = 0; i < 4; i++) begin
      m_state[i] = 0; m_chk[i] = 0; m_err[i] = 0; m_fe[i] = 0; m_fail[i] = 0; m_flush[i] = 0;
    end
  endtask

  // A sample accepted at edge s is judged at edge s+LAT, provided the run it
  // belongs to is still the current one and still running.
  task automatic model_update(input int k);
    int s, mx;
    bit cmp, mm;
    hld[k] = 4'b0;
    for (int i = 0; i < 4; i++) begin
      mx = (1 << CW[i]) - 1;
      if (rst) begin
        m_state[i] = 0; m_chk[i] = 0; m_err[i] = 0; m_fe[i] = 0; m_fail[i] = 0;
      end else if (m_state[i] == 0) begin
        if (en) begin
          m_state[i] = 1; m_chk[i] = 0; m_err[i] = 0; m_fe[i] = 0; m_fail[i] = 0; m_flush[i] = k;
        end
      end else if (m_state[i] == 1) begin
        s   = k - LAT[i];
        cmp = (s >= 1) && (s >= m_flush[i]) && hld[s][i];
        mm  = 1'b0;
        if (cmp) begin
          mm = hfs[s][i] | hfc[s][i];
          if (mm && !m_fail[i]) begin m_fail[i] = 1; m_fe[i] = m_chk[i]; end
          if (mm && m_err[i] < mx) m_err[i]++;
          if (m_chk[i] < mx) m_chk[i]++;
        end
        if (!en) m_state[i] = 0;
        else begin
          if (mm && STP[i] != 0) m_state[i] = 2;
          hld[k][i] = valid;
        end
      end else begin
        if (!en) m_state[i] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy_o[i] !== (m_state[i] == 1) || fail_o[i] !== m_fail[i] ||
          chk_a[i] != m_chk[i] || err_a[i] != m_err[i] || fe_a[i] != m_fe[i]) begin
        errors++;
        $display("FAIL %s u%0d cyc%0d: got busy=%0b fail=%0b chk=%0d err=%0d fe=%0d, want busy=%0b fail=%0b chk=%0d err=%0d fe=%0d",
                 tag, i, cyc, busy_o[i], fail_o[i], chk_a[i], err_a[i], fe_a[i],
                 (m_state[i] == 1), m_fail[i], m_chk[i], m_err[i], m_fe[i]);
      end
    end
  endtask

  task automatic chk_u(input string tag, input int i, input bit eb, input bit ef,
                       input int ec, input int ee, input int efe);
    checks++;
    if (busy_o[i] !== eb || fail_o[i] !== ef || chk_a[i] != ec || err_a[i] != ee || fe_a[i] != efe) begin
      errors++;
      $display("FAIL %s u%0d: got busy=%0b fail=%0b chk=%0d err=%0d fe=%0d, want busy=%0b fail=%0b chk=%0d err=%0d fe=%0d",
               tag, i, busy_o[i], fail_o[i], chk_a[i], err_a[i], fe_a[i], eb, ef, ec, ee, efe);
    end
  endtask

  task automatic drive(input logic e, input logic v, input logic aa, input logic bb,
                       input logic [3:0] sf, input logic [3:0] cf);
    en = e; valid = v; a = aa; b = bb; fs = sf; fc = cf;
  endtask

  // One clock: record the sample, advance the model, present each instance's
  // adder output (LAT cycles after its sample), then check on the falling edge.
  task automatic step();
    int idx;
    @(posedge clk);
    #1;
    cyc++;
    ha[cyc] = a; hb[cyc] = b; hfs[cyc] = fs; hfc[cyc] = fc;
    model_update(cyc);
    for (int i = 0; i < 4; i++) begin
      idx = cyc - LAT[i] + 1;
      if (idx >= 1) begin
        dsum[i] = (ha[idx] ^ hb[idx]) ^ hfs[idx][i];
        dcar[i] = (ha[idx] & hb[idx]) ^ hfc[idx][i];
      end else begin
        dsum[i] = 1'b0; dcar[i] = 1'b0;
      end
    end
    @(negedge clk);
    check_all("model");
  endtask

  task automatic rst_assert();
    rst = 1'b1;
    #1;
    model_zero();
    check_all("rst_async");
  endtask

  task automatic do_reset(input int n);
    drive(0, 0, 0, 0, 4'b0, 4'b0);
    rst_assert();
    repeat (n) step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic en, v, a, b, fs;
    logic ebusy, efail;
    int   echk, eerr, efe;
  } vec_t;

  vec_t tbl[14];

  initial begin
    checks = 0; errors = 0; cyc = 0;
    dsum = '0; dcar = '0;
    model_zero();

    // Two back-to-back runs on u0: all-correct, then sum inverted on ab=10.
    tbl[0]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    tbl[3]  = '{1, 1, 1, 0, 0, 1, 0, 2, 0, 0};
    tbl[4]  = '{1, 1, 1, 1, 0, 1, 0, 3, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 1, 0, 4, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 4, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[9]  = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    tbl[10] = '{1, 1, 1, 0, 1, 1, 0, 2, 0, 0};
    tbl[11] = '{1, 1, 1, 1, 0, 1, 1, 3, 1, 2};
    tbl[12] = '{1, 0, 0, 0, 0, 1, 1, 4, 1, 2};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 4, 1, 2};

    // Reset state
    do_reset(2);
    chk_u("reset", 0, 0, 0, 0, 0, 0);
    step();
    chk_u("idle_after_reset", 0, 0, 0, 0, 0, 0);

    for (int j = 0; j < 14; j++) begin
      drive(tbl[j].en, tbl[j].v, tbl[j].a, tbl[j].b, {4{tbl[j].fs}}, 4'b0);
      step();
      chk_u($sformatf("vec%0d", j), 0, tbl[j].ebusy, tbl[j].efail, tbl[j].echk, tbl[j].eerr, tbl[j].efe);
    end

    // Stop-on-fail: carry forced low on ab=11 as the second sample
    do_reset(1);
    drive(1, 0, 0, 0, 4'b0, 4'b0); step();
    drive(1, 1, 0, 0, 4'b0, 4'b0); step();
    drive(1, 1, 1, 1, 4'b0, 4'b1111); step();
    drive(1, 1, 0, 1, 4'b0, 4'b0); step();
    chk_u("halt_enter", 1, 0, 1, 2, 1, 1);
    repeat (3) begin drive(1, 1, 1, 0, 4'b0, 4'b0); step(); end
    chk_u("halt_frozen", 1, 0, 1, 2, 1, 1);
    drive(0, 0, 0, 0, 4'b0, 4'b0); step();
    chk_u("halt_to_idle", 1, 0, 1, 2, 1, 1);
    drive(1, 0, 0, 0, 4'b0, 4'b0); step();
    chk_u("restart", 1, 1, 0, 0, 0, 0);

    // Saturation with CNT_W=2
    do_reset(1);
    drive(1, 0, 0, 0, 4'b0, 4'b0); step();
    for (int j = 0; j < 6; j++) begin
      drive(1, 1, j[0], j[1], 4'b0, 4'b0); step();
    end
    drive(1, 1, 1, 1, 4'b1111, 4'b0); step();
    chk_u("sat_hold", 2, 1, 0, 3, 0, 0);
    drive(1, 0, 0, 0, 4'b0, 4'b0); step();
    chk_u("sat_fail", 2, 1, 1, 3, 1, 3);

    // LATENCY=3: reset with samples in flight
    do_reset(1);
    drive(1, 0, 0, 0, 4'b0, 4'b0); step();
    drive(1, 1, 1, 0, 4'b0, 4'b0); step();
    drive(1, 1, 1, 1, 4'b0, 4'b0); step();
    rst_assert();
    chk_u("rst_midrun", 3, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;

    // LATENCY=3: en dropped with samples in flight
    drive(1, 0, 0, 0, 4'b0, 4'b0); step();
    drive(1, 1, 0, 1, 4'b0, 4'b0); step();
    drive(1, 0, 0, 0, 4'b0, 4'b0);
    repeat (3) step();
    chk_u("lat3_count", 3, 1, 0, 1, 0, 0);
    drive(1, 1, 1, 1, 4'b0, 4'b0); step();
    drive(1, 1, 0, 0, 4'b0, 4'b0); step();
    drive(0, 0, 0, 0, 4'b0, 4'b0);
    repeat (5) step();
    chk_u("en_drop", 3, 0, 0, 1, 0, 0);

    // Randomized traffic against the model
    do_reset(1);
    en = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(39) == 0) en = ~en;
      valid = ($urandom_range(9) < 7);
      a = 1'($urandom);
      b = 1'($urandom);
      fs = ($urandom_range(15) == 0) ? 4'($urandom) : 4'b0;
      fc = ($urandom_range(15) == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(299) == 0) begin
        rst_assert();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
